rhb_bus_ctrl: RTL

//  Parametrised successor of the two-master/three-slave RHB bus. Connects NUM_M masters to NUM_S slaves.

---
 rtl/rhb_pkg.sv | 23 ++
 rtl/rhb_rr_arbiter.sv | 32 +++
 rtl/rhb_bus_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rhb_pkg.sv
// Shared types and constants for the RHB bus controller and its arbiter.
package rhb_pkg;

    typedef enum logic [2:0] {
        RHB_IDLE  = 3'd0,
        RHB_OWNED = 3'd1,
        RHB_BUSY  = 3'd2,
        RHB_DONE  = 3'd3,
        RHB_ERR   = 3'd4
    } rhb_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int ADDR_LEN_DEF = 32;
    localparam int DATA_LEN_DEF = 32;

    // Width needed to hold an index into n items; never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rhb_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr wins.
module rhb_rr_arbiter
    import rhb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            for (int i = 0; i < N; i++) begin
                if (i == cand && en && !found && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rhb_bus_ctrl.sv
// NUM_M-master / NUM_S-slave RHB bus: round-robin ownership, registered decode,
// slave ready/wait handshake with timeout, error response for unmapped slaves.
module rhb_bus_ctrl
    import rhb_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int NUM_S    = 4,
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_M-1:0]         m_req_,
    input  logic [NUM_M-1:0]         m_as_,
    input  logic [NUM_M-1:0]         m_rw,
    input  logic [NUM_M*ADDR_LEN-1:0] m_addr,
    input  logic [NUM_M*DATA_LEN-1:0] m_wr_data,
    output logic [NUM_M-1:0]         m_grnt,
    output logic                     m_rdy_,
    output logic                     m_err,
    output logic [DATA_LEN-1:0]      m_rd_data,
    output logic [ADDR_LEN-1:0]      s_addr,
    output logic [DATA_LEN-1:0]      s_wr_data,
    output logic                     s_rw,
    output logic                     s_as_,
    output logic [NUM_S-1:0]         s_sel_,
    input  logic [NUM_S-1:0]         s_rdy_,
    input  logic [NUM_S*DATA_LEN-1:0] s_rd_data,
    output rhb_state_e               dbg_state
);

    localparam int PW = idx_w(NUM_M);

    // Handshake: the owner holds m_req_ low for its tenure and strobes m_as_ in
    // OWNED; the slave selected by s_sel_ answers with s_rdy_ low while s_as_ is
    // low; the owner then sees a single low cycle of m_rdy_ (with m_err on error).

    rhb_state_e          state_q, state_d;
    logic [NUM_M-1:0]    grnt_q, grnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [ADDR_LEN-1:0] s_addr_q, s_addr_d;
    logic [DATA_LEN-1:0] s_wr_data_q, s_wr_data_d;
    logic                s_rw_q, s_rw_d;
    logic                s_as_q, s_as_d;
    logic [NUM_S-1:0]    s_sel_q, s_sel_d;
    logic [DATA_LEN-1:0] rd_q, rd_d;

    logic [NUM_M-1:0]    arb_gnt;
    logic [PW-1:0]       nxt_ptr;
    logic                own_req_n, own_as_n, own_rw;
    logic [ADDR_LEN-1:0] own_addr;
    logic [DATA_LEN-1:0] own_wdata;
    logic [SEL_W-1:0]    sel_idx;
    logic                mapped;
    logic [NUM_S-1:0]    dec_sel_n;
    logic                rdy_hit;
    logic [DATA_LEN-1:0] sel_rd;

    rhb_rr_arbiter #(.N(NUM_M), .PW(PW)) u_arb (
        .req (~m_req_),
        .ptr (ptr_q),
        .en  (state_q == RHB_IDLE),
        .gnt (arb_gnt)
    );

    always_comb begin
        nxt_ptr = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (arb_gnt[i]) nxt_ptr = (i == NUM_M - 1) ? '0 : PW'(i + 1);
        end
    end

    // Owner-side mux driven by the registered one-hot grant.
    always_comb begin
        own_req_n = 1'b1;
        own_as_n  = 1'b1;
        own_rw    = RW_READ;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grnt_q[i]) begin
                own_req_n = m_req_[i];
                own_as_n  = m_as_[i];
                own_rw    = m_rw[i];
                own_addr  = m_addr[i*ADDR_LEN +: ADDR_LEN];
                own_wdata = m_wr_data[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    assign sel_idx = own_addr[ADDR_LEN-1 -: SEL_W];
    assign mapped  = int'(sel_idx) < NUM_S;

    always_comb begin
        dec_sel_n = '1;
        rdy_hit   = 1'b0;
        sel_rd    = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (j == int'(sel_idx)) dec_sel_n[j] = 1'b0;
            if (!s_sel_q[j]) begin
                rdy_hit = rdy_hit | ~s_rdy_[j];
                sel_rd  = s_rd_data[j*DATA_LEN +: DATA_LEN];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grnt_d      = grnt_q;
        ptr_d       = ptr_q;
        tcnt_d      = tcnt_q;
        s_addr_d    = s_addr_q;
        s_wr_data_d = s_wr_data_q;
        s_rw_d      = s_rw_q;
        s_as_d      = s_as_q;
        s_sel_d     = s_sel_q;
        rd_d        = rd_q;
        case (state_q)
            RHB_IDLE: begin
                if (|arb_gnt) begin
                    state_d = RHB_OWNED;
                    grnt_d  = arb_gnt;
                    ptr_d   = nxt_ptr;
                end
            end
            RHB_OWNED: begin
                if (own_req_n) begin
                    state_d = RHB_IDLE;
                    grnt_d  = '0;
                end else if (!own_as_n) begin
                    if (mapped) begin
                        state_d     = RHB_BUSY;
                        s_addr_d    = own_addr;
                        s_wr_data_d = own_wdata;
                        s_rw_d      = own_rw;
                        s_as_d      = 1'b0;
                        s_sel_d     = dec_sel_n;
                    end else begin
                        state_d = RHB_ERR;
                    end
                end
            end
            RHB_BUSY: begin
                if (rdy_hit || tcnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = rdy_hit ? RHB_DONE : RHB_ERR;
                    if (rdy_hit && s_rw_q == RW_READ) rd_d = sel_rd;
                    s_as_d  = 1'b1;
                    s_sel_d = '1;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            RHB_DONE, RHB_ERR: state_d = RHB_OWNED;
            default: begin
                state_d = RHB_IDLE;
                grnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RHB_IDLE;
            grnt_q      <= '0;
            ptr_q       <= '0;
            tcnt_q      <= '0;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
            s_rw_q      <= RW_READ;
            s_as_q      <= 1'b1;
            s_sel_q     <= '1;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            grnt_q      <= grnt_d;
            ptr_q       <= ptr_d;
            tcnt_q      <= tcnt_d;
            s_addr_q    <= s_addr_d;
            s_wr_data_q <= s_wr_data_d;
            s_rw_q      <= s_rw_d;
            s_as_q      <= s_as_d;
            s_sel_q     <= s_sel_d;
            rd_q        <= rd_d;
        end
    end

    assign m_grnt    = grnt_q;
    assign m_rdy_    = !(state_q == RHB_DONE || state_q == RHB_ERR);
    assign m_err     = (state_q == RHB_ERR);
    assign m_rd_data = rd_q;
    assign s_addr    = s_addr_q;
    assign s_wr_data = s_wr_data_q;
    assign s_rw      = s_rw_q;
    assign s_as_     = s_as_q;
    assign s_sel_    = s_sel_q;
    assign dbg_state = state_q;

endmodule
